multicycle_ctrl: RTL

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_pkg.sv | 43 ++++
 rtl/multicycle_ctrl_if.sv | 10 +
 rtl/multicycle_ctrl_wait_timer.sv | 28 ++
 rtl/multicycle_ctrl.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle RV32 controller: states, opcodes and
// datapath select values.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_MEM  = 4'd8,
        S_EX_BR   = 4'd9,
        S_EX_JAL  = 4'd10,
        S_EX_JALR = 4'd11,
        S_HALT    = 4'd12,
        S_ERROR   = 4'd13
    } state_t;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [1:0] ALU_ADD    = 2'd0;
    localparam logic [1:0] ALU_BRANCH = 2'd1;
    localparam logic [1:0] ALU_FUNCT  = 2'd2;

    localparam logic [1:0] SRC_B_RS2  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [1:0] PC_SRC_ALU    = 2'd0;
    localparam logic [1:0] PC_SRC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd2;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Unified memory handshake between the controller and the memory.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic i_or_d;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output i_or_d, input mem_ready);
    modport slave  (input mem_req, input mem_we, input i_or_d, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// mem_wait_timer: counts stalled memory cycles and flags when the stall
// reaches TIMEOUT while the memory is still not ready.
module mem_wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic leave,
    output logic expired
);
    localparam int W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (leave || !waiting)
            cnt <= '0;
        else
            cnt <= cnt + W'(1);
    end

    // A ready in the limit cycle drops waiting, so completion beats the timeout.
    assign expired = (TIMEOUT != 0) && waiting && (cnt == LIMIT);
endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: sequences fetch/decode/execute/memory/writeback
// over a unified memory with a stall timeout and a retired-instruction counter.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [6:0]          opcode,
    input  logic                alu_bcond,
    input  logic                halt_req,
    multicycle_ctrl_if.master   bus,
    output logic                ir_write,
    output logic                pc_write,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                pc_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op_sel,
    output logic [1:0]          pc_source,
    output logic                is_halted,
    output logic                error,
    output logic [3:0]          state,
    output logic [CNT_W-1:0]    instret
);
    state_t cur, nxt;
    logic   mem_req_c, mem_we_c, i_or_d_c, pc_write_c, reg_write_c;
    logic   waiting, expired;

    assign waiting = (cur == S_FETCH || cur == S_MEM_RD || cur == S_MEM_WR) && !bus.mem_ready;

    mem_wait_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .waiting (waiting),
        .leave   (nxt != cur),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) cur <= S_FETCH;
        else       cur <= nxt;
    end

    always_comb begin
        nxt         = cur;
        mem_req_c   = 1'b0;
        mem_we_c    = 1'b0;
        i_or_d_c    = 1'b0;
        ir_write    = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        mem_to_reg  = 1'b0;
        pc_to_reg   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = SRC_B_RS2;
        alu_op_sel  = ALU_ADD;
        pc_source   = PC_SRC_ALU;
        case (cur)
            S_FETCH: begin
                mem_req_c = 1'b1;
                if (bus.mem_ready) begin
                    ir_write = 1'b1;
                    nxt      = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch/jump target PC+imm is parked in ALUOut here.
                alu_src_b = SRC_B_IMM;
                case (opcode)
                    OP_RTYPE:           nxt = S_EX_R;
                    OP_ITYPE:           nxt = S_EX_I;
                    OP_LOAD, OP_STORE:  nxt = S_EX_ADDR;
                    OP_BRANCH:          nxt = S_EX_BR;
                    OP_JAL:             nxt = S_EX_JAL;
                    OP_JALR:            nxt = S_EX_JALR;
                    OP_SYSTEM: begin
                        if (halt_req) nxt = S_HALT;
                        else begin
                            pc_write_c = 1'b1;
                            pc_source  = PC_SRC_PLUS4;
                            nxt        = S_FETCH;
                        end
                    end
                    default:            nxt = S_ERROR;
                endcase
            end
            S_EX_R: begin
                alu_src_a  = 1'b1;
                alu_op_sel = ALU_FUNCT;
                nxt        = S_WB_ALU;
            end
            S_EX_I: begin
                alu_src_a  = 1'b1;
                alu_src_b  = SRC_B_IMM;
                alu_op_sel = ALU_FUNCT;
                nxt        = S_WB_ALU;
            end
            S_EX_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRC_B_IMM;
                nxt       = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_req_c = 1'b1;
                i_or_d_c  = 1'b1;
                if (bus.mem_ready) nxt = S_WB_MEM;
            end
            S_MEM_WR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                i_or_d_c  = 1'b1;
                if (bus.mem_ready) begin
                    pc_write_c = 1'b1;
                    pc_source  = PC_SRC_PLUS4;
                    nxt        = S_FETCH;
                end
            end
            S_WB_ALU, S_WB_MEM: begin
                reg_write_c = 1'b1;
                mem_to_reg  = (cur == S_WB_MEM);
                pc_write_c  = 1'b1;
                pc_source   = PC_SRC_PLUS4;
                nxt         = S_FETCH;
            end
            S_EX_BR: begin
                alu_src_a  = 1'b1;
                alu_op_sel = ALU_BRANCH;
                pc_write_c = 1'b1;
                pc_source  = alu_bcond ? PC_SRC_ALUOUT : PC_SRC_PLUS4;
                nxt        = S_FETCH;
            end
            S_EX_JAL: begin
                reg_write_c = 1'b1;
                pc_to_reg   = 1'b1;
                pc_write_c  = 1'b1;
                pc_source   = PC_SRC_ALUOUT;
                nxt         = S_FETCH;
            end
            S_EX_JALR: begin
                reg_write_c = 1'b1;
                pc_to_reg   = 1'b1;
                pc_write_c  = 1'b1;
                alu_src_a   = 1'b1;
                alu_src_b   = SRC_B_IMM;
                pc_source   = PC_SRC_ALU;
                nxt         = S_FETCH;
            end
            S_HALT, S_ERROR: nxt = cur;
            default:         nxt = S_ERROR;
        endcase
        if (expired) nxt = S_ERROR;
    end

    // Architectural writes are masked while reset is asserted.
    assign bus.mem_req = mem_req_c;
    assign bus.mem_we  = mem_we_c & ~reset;
    assign bus.i_or_d  = i_or_d_c;
    assign pc_write    = pc_write_c & ~reset;
    assign reg_write   = reg_write_c & ~reset;
    assign is_halted   = (cur == S_HALT);
    assign error       = (cur == S_ERROR);
    assign state       = cur;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            instret <= '0;
        else if (cur != S_FETCH && nxt != cur && (nxt == S_FETCH || nxt == S_HALT))
            instret <= instret + CNT_W'(1);
    end
endmodule
